score_ctrl: RTL and testbench

- Game-control stage directly upstream of the per-digit score counters.
- Runs the IDLE/PLAY/OVER game FSM and decides when the bird has cleared a pipe.
- Drives the counters' `active` input (low clears the score to the load value) and a single-cycle `increment` pulse into the ones-digit counter.
- Also flags collisions and keeps a binary pass count for the high-score logic.

---
 rtl/score_ctrl_pkg.sv | 16 +
 rtl/score_ctrl_edge_rise.sv | 32 +++
 rtl/score_ctrl.sv | 107 ++++++++++
 tb/tb_score_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// score_ctrl_pkg
// Shared game definitions for the LED flappy-bird datapath.
//   ROWS_DEF     : default playfield height (rows), shared with pipe/bird logic
//   ST_IDLE/PLAY/OVER : game FSM state encodings
// -----------------------------------------------------------------------------
package score_ctrl_pkg;

  localparam int ROWS_DEF = 8;

  // Plain constants rather than an enum so legacy blocks can compare directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

endpackage

// File: rtl/score_ctrl_edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Rising-edge detector built on one registered previous-sample flop.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   din   : level input (already synchronized)
//   rise  : din & ~previous sample
// RESET_VAL sets the previous-sample flop at reset; 1 means a level held high
// through reset is not reported as an edge.
// -----------------------------------------------------------------------------
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= RESET_VAL;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
// Game FSM (IDLE/PLAY/OVER), pipe-pass detection and collision flagging that
// feed the per-digit score counters.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   start        : start/restart key, synchronized level, active high
//   pipe_col_hit : a pipe occupies the bird's column this cycle
//   gap_mask     : open rows of that pipe (1 = open), valid with pipe_col_hit
//   bird_row     : one-hot bird row (all-zero = off-grid)
//   bird_floor   : bird touching the ground
//   active       : low in IDLE so the score counters sit at their load value
//   increment    : one-cycle pulse per pipe cleared
//   game_over    : high in OVER
//   pass_count   : pipes cleared this game, saturating
// -----------------------------------------------------------------------------
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pipe_col_hit,
  input  logic [ROWS-1:0]  gap_mask,
  input  logic [ROWS-1:0]  bird_row,
  input  logic             bird_floor,
  output logic             active,
  output logic             increment,
  output logic             game_over,
  output logic [CNT_W-1:0] pass_count
);

  logic [1:0] state;
  logic       in_pipe;
  logic       hit_flag;
  logic       start_rise;
  logic       collide;
  logic       exit_pass;

  edge_rise #(.RESET_VAL(1'b1)) u_start_edge (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .rise  (start_rise)
  );

  // An off-grid (all-zero) bird row can never be inside the gap.
  assign collide = bird_floor
                 | (pipe_col_hit & ((bird_row & ~gap_mask) != '0))
                 | (pipe_col_hit & (bird_row == '0));

  // A pass is the falling edge of pipe_col_hit, provided the bird never touched
  // this pipe and is not colliding in the very cycle it leaves.
  assign exit_pass = (state == ST_PLAY) & in_pipe & ~pipe_col_hit
                   & ~hit_flag & ~collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      increment  <= 1'b0;
      pass_count <= '0;
      in_pipe    <= 1'b0;
      hit_flag   <= 1'b0;
    end else begin
      increment <= exit_pass;
      in_pipe   <= pipe_col_hit;
      case (state)
        ST_IDLE: begin
          pass_count <= '0;
          if (start_rise) begin
            state    <= ST_PLAY;
            in_pipe  <= 1'b0;
            hit_flag <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (collide) begin
            state    <= ST_OVER;
            hit_flag <= 1'b1;
          end else if (!pipe_col_hit) begin
            hit_flag <= 1'b0;
          end
          if (exit_pass && (pass_count != {CNT_W{1'b1}})) begin
            pass_count <= pass_count + 1'b1;
          end
        end
        ST_OVER: begin
          // Score stays frozen on the display until the player restarts.
          if (start_rise) begin
            state      <= ST_IDLE;
            pass_count <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign active    = (state != ST_IDLE);
  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
// Scoreboard bench for score_ctrl. Two instances share all inputs: one with
// the default 8-bit pass counter and one with a 2-bit counter to exercise
// saturation. Expected pass_count values are queued when a pipe is issued and
// popped by a monitor whenever a DUT pulses increment.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pipe_col_hit;
  logic [7:0] gap_mask;
  logic [7:0] bird_row;
  logic       bird_floor;

  logic       active_a, increment_a, game_over_a;
  logic [7:0] pass_count_a;
  logic       active_b, increment_b, game_over_b;
  logic [1:0] pass_count_b;

  int compared   = 0;
  int mismatched = 0;

  int q_a[$];
  int q_b[$];

  always #5 clk = ~clk;

  score_ctrl #(.ROWS(8), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pipe_col_hit (pipe_col_hit),
    .gap_mask     (gap_mask),
    .bird_row     (bird_row),
    .bird_floor   (bird_floor),
    .active       (active_a),
    .increment    (increment_a),
    .game_over    (game_over_a),
    .pass_count   (pass_count_a)
  );

  score_ctrl #(.ROWS(8), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pipe_col_hit (pipe_col_hit),
    .gap_mask     (gap_mask),
    .bird_row     (bird_row),
    .bird_floor   (bird_floor),
    .active       (active_b),
    .increment    (increment_b),
    .game_over    (game_over_b),
    .pass_count   (pass_count_b)
  );

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every increment pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (increment_a === 1'b1) begin
      if (q_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL inc_a: unexpected pulse, pass_count %0d, expected no pulse", pass_count_a);
      end else begin
        check("inc_a pass_count", int'(pass_count_a), q_a.pop_front());
      end
    end
    if (increment_b === 1'b1) begin
      if (q_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL inc_b: unexpected pulse, pass_count %0d, expected no pulse", pass_count_b);
      end else begin
        check("inc_b pass_count", int'(pass_count_b), q_b.pop_front());
      end
    end
  end

  // Pipe in the bird's column for n cycles, then two free cycles.
  task automatic run_pipe(input int n, input int exp_a, input int exp_b);
    q_a.push_back(exp_a);
    q_b.push_back(exp_b);
    pipe_col_hit = 1'b1;
    tick(n);
    pipe_col_hit = 1'b0;
    tick(2);
  endtask

  // From OVER: restart to IDLE, confirm IDLE holds, then enter PLAY.
  task automatic restart(input string tag);
    start = 1'b1;
    tick();
    check({tag, " idle active"}, int'(active_a), 0);
    check({tag, " idle pass_count"}, int'(pass_count_a), 0);
    start = 1'b0;
    tick();
    check({tag, " idle holds"}, int'(active_a), 0);
    start = 1'b1;
    tick();
    check({tag, " play active"}, int'(active_a), 1);
    start = 1'b0;
  endtask

  int tab_a[5] = '{1, 2, 3, 4, 5};
  int tab_b[5] = '{1, 2, 3, 3, 3};
  int len_tab[5] = '{3, 1, 4, 2, 2};

  initial begin
    reset        = 1'b0;
    start        = 1'b1;
    pipe_col_hit = 1'b0;
    gap_mask     = 8'b0000_0000;
    bird_row     = 8'b0001_0000;
    bird_floor   = 1'b0;
    tick(3);
    check("reset active", int'(active_a), 0);
    check("reset game_over", int'(game_over_a), 0);
    check("reset increment", int'(increment_a), 0);
    check("reset pass_count", int'(pass_count_a), 0);

    // Release with start still high: no game may begin.
    reset = 1'b1;
    tick(3);
    check("held start stays idle", int'(active_a), 0);

    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("start enters play", int'(active_a), 1);
    start = 1'b0;

    // Five clean passes; one is a single-cycle pipe, one changes gap mid-pipe
    // (back-to-back pipes with no free cycle count once).
    gap_mask = 8'b0011_1000;
    for (int p = 0; p < 5; p++) begin
      if (p == 2) begin
        q_a.push_back(tab_a[p]);
        q_b.push_back(tab_b[p]);
        pipe_col_hit = 1'b1;
        tick(2);
        gap_mask = 8'b0111_0000;
        tick(2);
        pipe_col_hit = 1'b0;
        gap_mask = 8'b0011_1000;
        tick(2);
      end else begin
        run_pipe(len_tab[p], tab_a[p], tab_b[p]);
      end
    end
    check("after 5 passes a", int'(pass_count_a), 5);
    check("after 5 passes b", int'(pass_count_b), 3);

    // Floor contact in the exit cycle: OVER, no pulse, count unchanged.
    pipe_col_hit = 1'b1;
    tick(2);
    pipe_col_hit = 1'b0;
    bird_floor   = 1'b1;
    tick();
    bird_floor = 1'b0;
    check("floor exit game_over", int'(game_over_a), 1);
    check("floor exit increment", int'(increment_a), 0);
    check("floor exit pass_count a", int'(pass_count_a), 5);
    check("floor exit pass_count b", int'(pass_count_b), 3);
    tick(2);
    check("over active", int'(active_a), 1);

    // Game 2: bird outside the gap.
    restart("g2");
    bird_row     = 8'b1000_0000;
    gap_mask     = 8'b0000_1110;
    pipe_col_hit = 1'b1;
    tick();
    check("wall hit game_over", int'(game_over_a), 1);
    check("wall hit active", int'(active_a), 1);
    tick();
    pipe_col_hit = 1'b0;
    tick();
    check("wall hit no increment", int'(increment_a), 0);
    tick();

    // Game 3: off-grid bird is never in the gap.
    restart("g3");
    bird_row     = 8'b0000_0000;
    gap_mask     = 8'b1111_1111;
    pipe_col_hit = 1'b1;
    tick();
    check("off-grid game_over", int'(game_over_a), 1);
    pipe_col_hit = 1'b0;
    bird_row     = 8'b0001_0000;
    gap_mask     = 8'b0011_1000;
    tick(2);

    // Game 4: reset in the middle of an increment pulse.
    restart("g4");
    pipe_col_hit = 1'b1;
    tick();
    pipe_col_hit = 1'b0;
    tick();
    check("pulse before reset", int'(increment_a), 1);
    check("count before reset", int'(pass_count_a), 1);
    #1 reset = 1'b0;
    #1;
    check("reset mid-pulse increment", int'(increment_a), 0);
    check("reset mid-pulse active", int'(active_a), 0);
    check("reset mid-pulse pass_count", int'(pass_count_a), 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    check("idle after reset", int'(active_a), 0);

    check("queue a drained", q_a.size(), 0);
    check("queue b drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
